// File: rtl/dma_burst_engine.sv
// dma_burst_engine: moves one 1024-bit operand between the RSA controller and
// memory as a burst of 32-bit beats over a request/acknowledge bus.
module dma_burst_engine #(
  parameter int unsigned BEATS   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  dma_rx_start,
  input  logic [31:0]           dma_rx_address,
  output logic [BEATS*32-1:0]   dma_rx_data,
  input  logic                  dma_tx_start,
  input  logic [31:0]           dma_tx_address,
  input  logic [BEATS*32-1:0]   dma_tx_data,
  output logic                  dma_done,
  output logic                  dma_idle,
  output logic                  dma_error,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_err
);

  localparam int unsigned DataW = BEATS * 32;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [31:0]        r_addr;
  logic [DataW-1:0]   r_buf;
  logic [DataW-1:0]   r_shadow;
  logic [DataW-1:0]   r_rx_data;
  logic [BeatW-1:0]   r_beat;
  logic [WaitW-1:0]   r_wait;
  logic               r_error;

  logic               w_busy;
  logic               w_start;
  logic [31:0]        w_start_addr;
  logic               w_misalign;
  logic               w_beat_ok;
  logic               w_last;
  logic               w_fault;
  logic [DataW-1:0]   w_shadow_next;

  // Event decode shared by the FSM and the datapath.
  always_comb begin
    w_busy        = (r_state == StRead) || (r_state == StWrite);
    w_start       = (r_state == StIdle) && (dma_rx_start || dma_tx_start);
    // Read wins when both starts arrive together.
    w_start_addr  = dma_rx_start ? dma_rx_address : dma_tx_address;
    w_misalign    = (w_start_addr[1:0] != 2'b00);
    w_beat_ok     = w_busy && mem_ack && !mem_err;
    w_last        = (r_beat == BeatW'(BEATS - 1));
    // Bus error on ack, or the beat has waited TIMEOUT cycles without an ack.
    w_fault       = w_busy && ((mem_ack && mem_err) ||
                               (!mem_ack && (r_wait == WaitW'(TIMEOUT - 1))));
    // Beats arrive LSW first, so shift new words in from the top.
    w_shadow_next = {mem_rdata, r_shadow[DataW-1:32]};
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          if (w_misalign)        w_state_next = StDone;
          else if (dma_rx_start) w_state_next = StRead;
          else                   w_state_next = StWrite;
        end
      end
      StRead, StWrite: begin
        if (w_fault || (w_beat_ok && w_last)) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Burst datapath: address, beat and wait counters, data buffers, error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr    <= '0;
      r_buf     <= '0;
      r_shadow  <= '0;
      r_rx_data <= '0;
      r_beat    <= '0;
      r_wait    <= '0;
      r_error   <= 1'b0;
    end else if (w_start) begin
      r_addr  <= w_start_addr;
      r_beat  <= '0;
      r_wait  <= '0;
      r_error <= w_misalign;
      if (!dma_rx_start) r_buf <= dma_tx_data;
    end else if (w_beat_ok) begin
      r_addr   <= r_addr + 32'd4;
      r_beat   <= r_beat + 1'b1;
      r_wait   <= '0;
      r_buf    <= r_buf >> 32;
      r_shadow <= w_shadow_next;
      // Only a complete, error-free read updates the visible operand.
      if ((r_state == StRead) && w_last) r_rx_data <= w_shadow_next;
    end else if (w_fault) begin
      r_error <= 1'b1;
    end else if (w_busy) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  // Outputs decode from state so reset clears them without a clock.
  always_comb begin
    mem_req     = w_busy;
    mem_we      = (r_state == StWrite);
    mem_addr    = r_addr;
    mem_wdata   = r_buf[31:0];
    dma_done    = (r_state == StDone);
    dma_idle    = (r_state == StIdle);
    dma_error   = r_error;
    dma_rx_data = r_rx_data;
  end

endmodule

// File: tb/tb_dma_burst_engine.sv
// Scoreboard bench for dma_burst_engine: a memory model answers beats, a
// monitor pops expected beats and completions as the DUT presents them.
module tb_dma_burst_engine;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          dma_rx_start = 1'b0;
  logic [31:0]   dma_rx_address = '0;
  logic [1023:0] dma_rx_data;
  logic          dma_tx_start = 1'b0;
  logic [31:0]   dma_tx_address = '0;
  logic [1023:0] dma_tx_data = '0;
  logic          dma_done;
  logic          dma_idle;
  logic          dma_error;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          mem_err = 1'b0;

  dma_burst_engine #(.BEATS(32), .TIMEOUT(255)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .dma_rx_start   (dma_rx_start),
    .dma_rx_address (dma_rx_address),
    .dma_rx_data    (dma_rx_data),
    .dma_tx_start   (dma_tx_start),
    .dma_tx_address (dma_tx_address),
    .dma_tx_data    (dma_tx_data),
    .dma_done       (dma_done),
    .dma_idle       (dma_idle),
    .dma_error      (dma_error),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic          err;
    logic [1023:0] rx;
    int            cyc;
  } done_t;

  beat_t exp_beats[$];
  done_t exp_done[$];
  logic [1023:0] exp_rx = '0;

  int n_chk = 0;
  int n_fail = 0;
  int t0 = 0;

  // Memory model configuration.
  logic [31:0] rd_base = '0;
  logic [31:0] rd_salt = '0;
  int          mem_wait = 0;
  int          err_beat = -1;
  bit          no_ack = 1'b0;
  int          wcnt = 0;
  int          bidx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rx(input string name, input logic [1023:0] exp);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("%s[%0d]", name, k), dma_rx_data[32*k +: 32], exp[32*k +: 32]);
    end
  endtask

  function automatic logic [1023:0] rd_image(input logic [31:0] salt);
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[32*k +: 32] = 32'(k + 1) + salt;
    return v;
  endfunction

  task automatic push_beats(input logic [31:0] base, input int n, input bit we,
                            input logic [1023:0] td);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.addr  = base + 32'(4 * k);
      b.we    = we;
      b.wdata = td[32*k +: 32];
      exp_beats.push_back(b);
    end
  endtask

  task automatic push_done(input logic err, input logic [1023:0] rx, input int c);
    done_t d;
    d.err = err;
    d.rx  = rx;
    d.cyc = c;
    exp_done.push_back(d);
  endtask

  // Memory responder: decides ack for the current cycle at each falling edge.
  always @(negedge clk) begin
    if (!mem_req) begin
      wcnt    = 0;
      bidx    = 0;
      mem_ack = 1'b0;
      mem_err = 1'b0;
    end else if (no_ack || (wcnt < mem_wait)) begin
      mem_ack = 1'b0;
      mem_err = 1'b0;
      wcnt++;
    end else begin
      mem_ack   = 1'b1;
      mem_rdata = ((mem_addr - rd_base) >> 2) + 32'd1 + rd_salt;
      mem_err   = (bidx == err_beat);
      bidx++;
      wcnt = 0;
    end
  end

  // Monitor: compares every acked beat and every completion against the queues.
  bit    prev_done = 1'b0;
  beat_t mb;
  done_t md;
  always @(negedge clk) begin
    #1;
    if (prev_done) chk("idle_after_done", 32'(dma_idle), 32'd1);
    prev_done = dma_done;
    if (mem_req && mem_ack) begin
      if (exp_beats.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got beat at %0h expected none", mem_addr);
      end else begin
        mb = exp_beats.pop_front();
        chk("mem_addr", mem_addr, mb.addr);
        chk("mem_we", 32'(mem_we), 32'(mb.we));
        if (mb.we) chk("mem_wdata", mem_wdata, mb.wdata);
      end
    end
    if (dma_done) begin
      if (exp_done.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc - t0 + 1);
      end else begin
        md = exp_done.pop_front();
        chk("done_cycle", 32'(cyc - t0 + 1), 32'(md.cyc));
        chk("dma_error", 32'(dma_error), 32'(md.err));
        chk("mem_req_in_done", 32'(mem_req), 32'd0);
        chk_rx("rx_data", md.rx);
      end
    end
  end

  task automatic start(input bit rd, input bit wr, input logic [31:0] ra,
                       input logic [31:0] wa, input logic [1023:0] td);
    @(negedge clk);
    dma_rx_start   = rd;
    dma_tx_start   = wr;
    dma_rx_address = ra;
    dma_tx_address = wa;
    dma_tx_data    = td;
    @(posedge clk);
    #1;
    dma_rx_start = 1'b0;
    dma_tx_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!dma_idle && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    #2;
    n_chk++;
    if (!dma_idle) begin
      n_fail++;
      $display("FAIL %s_idle: got dma_idle 0 after %0d cycles expected 1", name, budget);
    end
    chk({name, "_beats_left"}, 32'(exp_beats.size()), 32'd0);
    chk({name, "_done_left"}, 32'(exp_done.size()), 32'd0);
    exp_beats.delete();
    exp_done.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] td;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_idle", 32'(dma_idle), 32'd1);
    chk("rst_done", 32'(dma_done), 32'd0);
    chk("rst_error", 32'(dma_error), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk_rx("rst_rx", '0);
    @(negedge clk);
    resetn = 1'b1;

    // Zero-wait read at 0x1000; word k reads back as k+1.
    rd_base = 32'h1000;
    rd_salt = 32'd0;
    push_beats(32'h1000, 32, 1'b0, '0);
    exp_rx = rd_image(32'd0);
    push_done(1'b0, exp_rx, 33);
    start(1'b1, 1'b0, 32'h1000, 32'h0, '0);
    #1;
    chk("t1_busy_cycle1", 32'(dma_idle), 32'd0);
    wait_idle(100, "t1");
    chk("t1_rx_lsw", dma_rx_data[31:0], 32'd1);
    chk("t1_rx_msw", dma_rx_data[1023:992], 32'd32);

    // Write with one wait cycle per beat; only beat 31 carries bit 8.
    mem_wait = 1;
    td = 1024'h1;
    td = td << 1000;
    push_beats(32'h2000, 32, 1'b1, td);
    push_done(1'b0, exp_rx, 65);
    start(1'b0, 1'b1, 32'h0, 32'h2000, td);
    wait_idle(200, "t2");
    mem_wait = 0;

    // Bus error on beat 5 of a read; operand must stay unchanged.
    rd_salt  = 32'h100;
    err_beat = 5;
    push_beats(32'h1000, 6, 1'b0, '0);
    push_done(1'b1, exp_rx, 7);
    start(1'b1, 1'b0, 32'h1000, 32'h0, '0);
    wait_idle(100, "t3");
    err_beat = -1;

    // No ack on beat 0: abort after 255 wait cycles; new start clears error.
    no_ack = 1'b1;
    push_done(1'b1, exp_rx, 256);
    start(1'b1, 1'b0, 32'h4000, 32'h0, '0);
    #1;
    chk("t4_error_cleared", 32'(dma_error), 32'd0);
    chk("t4_addr_held", mem_addr, 32'h4000);
    wait_idle(400, "t4");
    no_ack = 1'b0;

    // Misaligned address: immediate done, no bus traffic.
    push_done(1'b1, exp_rx, 1);
    start(1'b1, 1'b0, 32'h1002, 32'h0, '0);
    #1;
    chk("t5_no_req", 32'(mem_req), 32'd0);
    wait_idle(10, "t5");

    // Both starts together: read wins; a tx pulse mid-read is ignored.
    rd_salt = 32'h200;
    push_beats(32'h1000, 32, 1'b0, '0);
    exp_rx = rd_image(32'h200);
    push_done(1'b0, exp_rx, 33);
    start(1'b1, 1'b1, 32'h1000, 32'h5000, '1);
    repeat (9) @(negedge clk);
    dma_tx_start   = 1'b1;
    dma_tx_address = 32'h5000;
    @(negedge clk);
    dma_tx_start = 1'b0;
    wait_idle(100, "t6");

    // Reset during beat 10, then a clean read.
    rd_base = 32'h6000;
    rd_salt = 32'h300;
    push_beats(32'h6000, 11, 1'b0, '0);
    start(1'b1, 1'b0, 32'h6000, 32'h0, '0);
    repeat (11) @(negedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("t7_rst_req", 32'(mem_req), 32'd0);
    chk("t7_rst_idle", 32'(dma_idle), 32'd1);
    chk("t7_rst_done", 32'(dma_done), 32'd0);
    chk("t7_rst_addr", mem_addr, 32'd0);
    chk("t7_rst_rx_lsw", dma_rx_data[31:0], 32'd0);
    chk("t7_beats_seen", 32'(exp_beats.size()), 32'd0);
    exp_rx = '0;
    @(negedge clk);
    resetn = 1'b1;
    push_beats(32'h6000, 32, 1'b0, '0);
    exp_rx = rd_image(32'h300);
    push_done(1'b0, exp_rx, 33);
    start(1'b1, 1'b0, 32'h6000, 32'h0, '0);
    wait_idle(100, "t8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
